// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite master: response codes, FSM encoding,
// default protection bits and the watchdog counter width helper.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_D  = 3'd2,
        ST_WR_AW = 3'd3,
        ST_WR_B  = 3'd4,
        ST_RSP   = 3'd5
    } mst_state_e;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;
    localparam int TMO_MIN_W = 8;
    localparam int TMO_MAX_W = 16;

    // Watchdog counter width: enough for the limit, clamped to 8..16 bits.
    function automatic int tmo_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < TMO_MIN_W) ? TMO_MIN_W : ((w > TMO_MAX_W) ? TMO_MAX_W : w);
    endfunction

endpackage

// File: rtl/axi_lite_wr_chan.sv
// Write address/data channel control: AW and W valids complete independently,
// per-channel done flags record which handshake has already happened.
module axi_lite_wr_chan (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic start,
    input  logic abort,
    input  logic active,
    input  logic AWREADY,
    input  logic WREADY,
    output logic AWVALID,
    output logic WVALID,
    output logic both_done
);

    logic awvalid_r;
    logic wvalid_r;
    logic aw_done_r;
    logic w_done_r;
    logic aw_hs_s;
    logic w_hs_s;

    // Handshake detection; a channel counts as done on the cycle of its handshake.
    always_comb begin
        aw_hs_s   = awvalid_r && AWREADY;
        w_hs_s    = wvalid_r && WREADY;
        both_done = active && (aw_done_r || aw_hs_s) && (w_done_r || w_hs_s);
    end

    // Valid and done-flag registers.
    always_ff @(posedge ACLK) begin
        if (ARESETN || abort) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else if (start) begin
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else if (active) begin
            if (aw_hs_s) begin
                awvalid_r <= 1'b0;
                aw_done_r <= 1'b1;
            end
            if (w_hs_s) begin
                wvalid_r <= 1'b0;
                w_done_r <= 1'b1;
            end
            if (both_done) begin
                aw_done_r <= 1'b0;
                w_done_r  <= 1'b0;
            end
        end
    end

    assign AWVALID = awvalid_r;
    assign WVALID  = wvalid_r;

endmodule

// File: rtl/axi_lite_master_ctl.sv
// Single-outstanding AXI4-Lite master bridging a valid/ready request/response port.
// Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_lite_master_ctl
    import axi_lite_pkg::*;
#(
    parameter int         ADDR_W         = 32,
    parameter int         DATA_W         = 32,
    parameter logic [2:0] PROT_VAL       = PROT_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 255,
    localparam int        STRB_W         = DATA_W / 8
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [2:0]        ARPROT,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [2:0]        AWPROT,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic [STRB_W-1:0] WSTRB,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY
);

    mst_state_e        state_r, state_nxt;
    logic [ADDR_W-1:0] addr_r, addr_nxt;
    logic [DATA_W-1:0] wdata_r, wdata_nxt;
    logic [STRB_W-1:0] wstrb_r, wstrb_nxt;
    logic              arvalid_r, arvalid_nxt;
    logic              rready_r, rready_nxt;
    logic              bready_r, bready_nxt;
    logic              req_ready_r, req_ready_nxt;
    logic              rsp_valid_r, rsp_valid_nxt;
    logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_nxt;
    logic [1:0]        rsp_resp_r, rsp_resp_nxt;
    logic              wr_start_s;
    logic              wr_both_done_s;
    logic              timeout_s;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int               TMO_W    = tmo_width(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             waiting_s;

    // Fires on the cycle that would complete TIMEOUT_CYCLES cycles in a wait state.
    always_comb begin
        waiting_s = (state_r == ST_RD_A) || (state_r == ST_RD_D) ||
                    (state_r == ST_WR_AW) || (state_r == ST_WR_B);
        timeout_s = waiting_s && (tmo_cnt_r == TMO_LAST);
    end

    // Watchdog counter, cleared on every state entry.
    always_ff @(posedge ACLK) begin
        if (ARESETN) begin
            tmo_cnt_r <= '0;
        end else if (state_nxt != state_r) begin
            tmo_cnt_r <= '0;
        end else if (waiting_s) begin
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
        end
    end
`else
    logic [31:0] unused_tmo_s;
    assign unused_tmo_s = 32'(TIMEOUT_CYCLES);
    assign timeout_s    = 1'b0;
`endif

    axi_lite_wr_chan u_wr_chan (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .start     (wr_start_s),
        .abort     (timeout_s),
        .active    (state_r == ST_WR_AW),
        .AWREADY   (AWREADY),
        .WREADY    (WREADY),
        .AWVALID   (AWVALID),
        .WVALID    (WVALID),
        .both_done (wr_both_done_s)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state_r;
        addr_nxt      = addr_r;
        wdata_nxt     = wdata_r;
        wstrb_nxt     = wstrb_r;
        arvalid_nxt   = arvalid_r;
        rready_nxt    = rready_r;
        bready_nxt    = bready_r;
        req_ready_nxt = req_ready_r;
        rsp_valid_nxt = rsp_valid_r;
        rsp_rdata_nxt = rsp_rdata_r;
        rsp_resp_nxt  = rsp_resp_r;
        wr_start_s    = 1'b0;
        if (timeout_s) begin
            arvalid_nxt   = 1'b0;
            rready_nxt    = 1'b0;
            bready_nxt    = 1'b0;
            rsp_valid_nxt = 1'b1;
            rsp_rdata_nxt = '0;
            rsp_resp_nxt  = RESP_SLVERR;
            state_nxt     = ST_RSP;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        addr_nxt      = req_addr;
                        wdata_nxt     = req_wdata;
                        wstrb_nxt     = req_wstrb;
                        req_ready_nxt = 1'b0;
                        if (req_write) begin
                            wr_start_s = 1'b1;
                            state_nxt  = ST_WR_AW;
                        end else begin
                            arvalid_nxt = 1'b1;
                            state_nxt   = ST_RD_A;
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_RD_A: begin
                    if (arvalid_r && ARREADY) begin
                        arvalid_nxt = 1'b0;
                        rready_nxt  = 1'b1;
                        state_nxt   = ST_RD_D;
                    end else begin
                        state_nxt = ST_RD_A;
                    end
                end
                ST_RD_D: begin
                    if (rready_r && RVALID) begin
                        rsp_rdata_nxt = RDATA;
                        rsp_resp_nxt  = RRESP;
                        rready_nxt    = 1'b0;
                        rsp_valid_nxt = 1'b1;
                        state_nxt     = ST_RSP;
                    end else begin
                        state_nxt = ST_RD_D;
                    end
                end
                ST_WR_AW: begin
                    if (wr_both_done_s) begin
                        bready_nxt = 1'b1;
                        state_nxt  = ST_WR_B;
                    end else begin
                        state_nxt = ST_WR_AW;
                    end
                end
                ST_WR_B: begin
                    if (bready_r && BVALID) begin
                        rsp_resp_nxt  = BRESP;
                        rsp_rdata_nxt = '0;
                        bready_nxt    = 1'b0;
                        rsp_valid_nxt = 1'b1;
                        state_nxt     = ST_RSP;
                    end else begin
                        state_nxt = ST_WR_B;
                    end
                end
                ST_RSP: begin
                    if (rsp_valid_r && rsp_ready) begin
                        rsp_valid_nxt = 1'b0;
                        req_ready_nxt = 1'b1;
                        state_nxt     = ST_IDLE;
                    end else begin
                        state_nxt = ST_RSP;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge ACLK) begin
        if (ARESETN) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            wdata_r     <= '0;
            wstrb_r     <= '0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            bready_r    <= 1'b0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_resp_r  <= 2'b00;
        end else begin
            state_r     <= state_nxt;
            addr_r      <= addr_nxt;
            wdata_r     <= wdata_nxt;
            wstrb_r     <= wstrb_nxt;
            arvalid_r   <= arvalid_nxt;
            rready_r    <= rready_nxt;
            bready_r    <= bready_nxt;
            req_ready_r <= req_ready_nxt;
            rsp_valid_r <= rsp_valid_nxt;
            rsp_rdata_r <= rsp_rdata_nxt;
            rsp_resp_r  <= rsp_resp_nxt;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_resp  = rsp_resp_r;
    assign ARADDR    = addr_r;
    assign ARPROT    = PROT_VAL;
    assign ARVALID   = arvalid_r;
    assign RREADY    = rready_r;
    assign AWADDR    = addr_r;
    assign AWPROT    = PROT_VAL;
    assign WDATA     = wdata_r;
    assign WSTRB     = wstrb_r;
    assign BREADY    = bready_r;

endmodule

// File: tb/tb_axi_lite_master_ctl.sv
// Self-checking bench for axi_lite_master_ctl: cycle-accurate scenario tasks with a
// response scoreboard; the watchdog scenario runs when AXI_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_master_ctl;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
    logic [2:0]  ARPROT, AWPROT;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [1:0]  RRESP, BRESP;
    logic [3:0]  WSTRB;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    always #5 ACLK = ~ACLK;

    axi_lite_master_ctl #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .PROT_VAL       (3'b000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .ARADDR    (ARADDR),
        .ARPROT    (ARPROT),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .AWADDR    (AWADDR),
        .AWPROT    (AWPROT),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY)
    );

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic slave_idle();
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    endtask

    task automatic test_reset();
        ARESETN = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_wstrb = 4'h0; rsp_ready = 1'b0;
        slave_idle();
        tick(); tick();
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if ({ARVALID, AWVALID, WVALID, RREADY, BREADY, rsp_valid} !== 6'b000000) begin
            fails++; $display("FAIL reset_handshakes: got %b want 000000", {ARVALID, AWVALID, WVALID, RREADY, BREADY, rsp_valid}); end
        checks++; if ({ARADDR, WDATA, WSTRB, rsp_rdata, rsp_resp} !== 102'h0) begin
            fails++; $display("FAIL reset_regs: addr %h wdata %h strb %h rdata %h resp %b", ARADDR, WDATA, WSTRB, rsp_rdata, rsp_resp); end
        checks++; if ({ARPROT, AWPROT} !== 6'b000000) begin fails++; $display("FAIL reset_prot: got %b want 000000", {ARPROT, AWPROT}); end
        ARESETN = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL post_reset_idle: req_ready %b rsp_valid %b want 1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_read();
        exp_t e;
        rsp_ready = 1'b1; ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'hDEADBEEF; RRESP = 2'b00;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040;
        exp_q.push_back('{32'hDEADBEEF, 2'b00});
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL read_ready_before: got %b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        checks++; if (ARVALID !== 1'b1 || ARADDR !== 32'h40 || req_ready !== 1'b0) begin
            fails++; $display("FAIL read_ar: arvalid %b araddr %h req_ready %b want 1/40/0", ARVALID, ARADDR, req_ready); end
        tick();
        checks++; if (ARVALID !== 1'b0 || RREADY !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL read_r: arvalid %b rready %b rsp_valid %b want 0/1/0", ARVALID, RREADY, rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || RREADY !== 1'b0) begin
            fails++; $display("FAIL read_rsp_valid: rsp_valid %b rready %b want 1/0", rsp_valid, RREADY); end
        if (exp_q.size() == 0) begin fails++; $display("FAIL read_scoreboard: queue empty"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
                fails++; $display("FAIL read_data: got %h/%b want %h/%b", rsp_rdata, rsp_resp, e.rdata, e.resp); end
        end
        tick();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL read_done: rsp_valid %b req_ready %b want 0/1", rsp_valid, req_ready); end
        slave_idle();
    endtask

    task automatic test_write_skew();
        exp_t e;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1000; req_wdata = 32'hA5A5A5A5; req_wstrb = 4'b0011;
        exp_q.push_back('{32'h0, 2'b10});
        tick();
        req_valid = 1'b0;
        checks++; if (AWVALID !== 1'b1 || WVALID !== 1'b1 || AWADDR !== 32'h1000 || WDATA !== 32'hA5A5A5A5 || WSTRB !== 4'b0011) begin
            fails++; $display("FAIL wr_issue: awv %b wv %b addr %h data %h strb %b", AWVALID, WVALID, AWADDR, WDATA, WSTRB); end
        WREADY = 1'b1;
        tick();
        WREADY = 1'b0;
        checks++; if (WVALID !== 1'b0 || AWVALID !== 1'b1 || BREADY !== 1'b0) begin
            fails++; $display("FAIL wr_w_first: wv %b awv %b bready %b want 0/1/0", WVALID, AWVALID, BREADY); end
        tick();
        checks++; if (AWVALID !== 1'b1 || BREADY !== 1'b0) begin
            fails++; $display("FAIL wr_aw_held: awv %b bready %b want 1/0", AWVALID, BREADY); end
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        checks++; if (AWVALID !== 1'b0 || BREADY !== 1'b1) begin
            fails++; $display("FAIL wr_both_done: awv %b bready %b want 0/1", AWVALID, BREADY); end
        BVALID = 1'b1; BRESP = 2'b10;
        tick();
        BVALID = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || BREADY !== 1'b0) begin
            fails++; $display("FAIL wr_rsp_valid: rsp_valid %b bready %b want 1/0", rsp_valid, BREADY); end
        if (exp_q.size() == 0) begin fails++; $display("FAIL wr_scoreboard: queue empty"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
                fails++; $display("FAIL wr_resp: got %h/%b want %h/%b", rsp_rdata, rsp_resp, e.rdata, e.resp); end
        end
        tick();
        slave_idle();
    endtask

    task automatic test_rsp_backpressure();
        exp_t e;
        rsp_ready = 1'b0; ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'h12345678; RRESP = 2'b01;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0100;
        exp_q.push_back('{32'h12345678, 2'b01});
        tick();
        req_write = 1'b1; req_addr = 32'h2000; req_wdata = 32'h11223344; req_wstrb = 4'hF;
        tick(); tick();
        slave_idle();
        if (exp_q.size() == 0) begin fails++; $display("FAIL bp_scoreboard: queue empty"); end
        else begin
            e = exp_q.pop_front();
            for (int i = 0; i < 5; i++) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_resp !== e.resp || req_ready !== 1'b0) begin
                    fails++; $display("FAIL bp_hold[%0d]: valid %b data %h resp %b req_ready %b", i, rsp_valid, rsp_rdata, rsp_resp, req_ready); end
                tick();
            end
        end
        rsp_ready = 1'b1; AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
        exp_q.push_back('{32'h0, 2'b00});
        tick();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || AWVALID !== 1'b0) begin
            fails++; $display("FAIL bp_no_same_cycle: rsp_valid %b req_ready %b awvalid %b want 0/1/0", rsp_valid, req_ready, AWVALID); end
        tick();
        req_valid = 1'b0;
        checks++; if (AWVALID !== 1'b1 || AWADDR !== 32'h2000) begin
            fails++; $display("FAIL bp_second_accept: awvalid %b awaddr %h want 1/2000", AWVALID, AWADDR); end
        tick(); tick();
        if (exp_q.size() == 0) begin fails++; $display("FAIL bp_wr_scoreboard: queue empty"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
                fails++; $display("FAIL bp_wr_rsp: valid %b got %h/%b want %h/%b", rsp_valid, rsp_rdata, rsp_resp, e.rdata, e.resp); end
        end
        tick();
        slave_idle();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1; ARREADY = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0200;
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (RREADY !== 1'b1) begin fails++; $display("FAIL rst_mid_rd_d: rready %b want 1", RREADY); end
        ARESETN = 1'b1;
        tick();
        ARESETN = 1'b0;
        checks++; if ({req_ready, ARVALID, RREADY, rsp_valid} !== 4'b1000 || ARADDR !== 32'h0) begin
            fails++; $display("FAIL rst_mid_values: rr/arv/rrdy/rspv %b araddr %h", {req_ready, ARVALID, RREADY, rsp_valid}, ARADDR); end
        RVALID = 1'b1; RDATA = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rsp_valid !== 1'b0 || RREADY !== 1'b0) begin
                fails++; $display("FAIL rst_mid_no_rsp[%0d]: rsp_valid %b rready %b want 0/0", i, rsp_valid, RREADY); end
        end
        slave_idle();
    endtask

    task automatic test_write_same_cycle();
        exp_t e;
        rsp_ready = 1'b1; AWREADY = 1'b1; WREADY = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h3000; req_wdata = 32'hCAFEF00D; req_wstrb = 4'b0000;
        exp_q.push_back('{32'h0, 2'b00});
        tick();
        req_valid = 1'b0;
        checks++; if (AWVALID !== 1'b1 || WVALID !== 1'b1 || WSTRB !== 4'b0000) begin
            fails++; $display("FAIL same_issue: awv %b wv %b strb %b want 1/1/0000", AWVALID, WVALID, WSTRB); end
        tick();
        AWREADY = 1'b0; WREADY = 1'b0;
        checks++; if (AWVALID !== 1'b0 || WVALID !== 1'b0 || BREADY !== 1'b1) begin
            fails++; $display("FAIL same_done: awv %b wv %b bready %b want 0/0/1", AWVALID, WVALID, BREADY); end
        BVALID = 1'b1; BRESP = 2'b00;
        tick();
        BVALID = 1'b0;
        if (exp_q.size() == 0) begin fails++; $display("FAIL same_scoreboard: queue empty"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
                fails++; $display("FAIL same_rsp: valid %b got %h/%b want %h/%b", rsp_valid, rsp_rdata, rsp_resp, e.rdata, e.resp); end
        end
        tick();
        slave_idle();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] d;
        logic [1:0]  r;
        rsp_ready = 1'b1; ARREADY = 1'b1; RVALID = 1'b1; AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = $urandom(); r = 2'($urandom_range(3, 0));
            req_write = i[0]; req_addr = 32'h4000 + 32'(i * 4); req_wdata = $urandom(); req_wstrb = 4'($urandom_range(15, 0));
            RDATA = d; RRESP = r; BRESP = r;
            exp_q.push_back('{(i[0] ? 32'h0 : d), r});
            req_valid = 1'b1;
            checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready); end
            tick();
            req_valid = 1'b0;
            tick(); tick();
            if (exp_q.size() == 0) begin fails++; $display("FAIL b2b_scoreboard[%0d]: queue empty", i); end
            else begin
                e = exp_q.pop_front();
                checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
                    fails++; $display("FAIL b2b_rsp[%0d]: valid %b got %h/%b want %h/%b", i, rsp_valid, rsp_rdata, rsp_resp, e.rdata, e.resp); end
            end
            tick();
        end
        slave_idle();
    endtask

`ifdef AXI_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0500;
        exp_q.push_back('{32'h0, 2'b10});
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++; if (ARVALID !== 1'b1) begin fails++; $display("FAIL tmo_arvalid_held[%0d]: got %b want 1", i, ARVALID); end
            tick();
        end
        checks++; if (ARVALID !== 1'b0 || RREADY !== 1'b0) begin
            fails++; $display("FAIL tmo_drop: arvalid %b rready %b want 0/0", ARVALID, RREADY); end
        if (exp_q.size() == 0) begin fails++; $display("FAIL tmo_scoreboard: queue empty"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
                fails++; $display("FAIL tmo_rsp: valid %b got %h/%b want %h/%b", rsp_valid, rsp_rdata, rsp_resp, e.rdata, e.resp); end
        end
        tick();
        ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'hFFFF0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({ARVALID, RREADY, rsp_valid, req_ready} !== 4'b0001) begin
                fails++; $display("FAIL tmo_late[%0d]: arv/rrdy/rspv/rr %b want 0001", i, {ARVALID, RREADY, rsp_valid, req_ready}); end
        end
        slave_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write_skew();
        test_rsp_backpressure();
        test_reset_mid();
        test_write_same_cycle();
        test_back_to_back();
`ifdef AXI_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drained: %0d left want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/axi_lite_master_ctl.md
Name: axi_lite_master_ctl

Overview:
- Parametrised successor to the single-shot AXI-Lite master.
- Converts a valid/ready request port from the core (fetch/LSU) into one AXI4-Lite read or write transaction, then returns data and response on a valid/ready response port.
- One outstanding transaction. AW and W channels complete independently. Full byte strobes. The request and response interfaces are fully handshaked.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (32 or 64); STRB_W = DATA_W/8
- PROT_VAL, 3'b000, constant driven on ARPROT/AWPROT
- TIMEOUT_CYCLES, 255, watchdog limit (used only with the optional feature)

Ports:
- ACLK  in  1  clock; all logic on the rising edge
- ARESETN  in  1  synchronous, active-high reset: state is reset when ARESETN=1 at a rising edge of ACLK
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_wstrb  in  STRB_W  write byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer ready
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_resp  out  2  RRESP/BRESP of the transaction
- ARADDR/ARPROT/ARVALID  out  ADDR_W/3/1  read address channel
- ARREADY  in  1
- RDATA/RRESP/RVALID  in  DATA_W/2/1  read data channel
- RREADY  out  1
- AWADDR/AWPROT/AWVALID  out  ADDR_W/3/1  write address channel
- AWREADY  in  1
- WDATA/WSTRB/WVALID  out  DATA_W/STRB_W/1  write data channel
- WREADY  in  1  (input, driven by the slave)
- BRESP/BVALID  in  2/1  write response channel
- BREADY  out  1

Behaviour:
- Reset values: every VALID/READY output 0 except req_ready=1; all address, data, strobe and response registers 0; FSM in IDLE. Reset mid-transaction abandons the transaction; no response is produced.
- FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B, RSP. All outputs are registered.
- IDLE: req_ready=1. On accept, latch addr/wdata/wstrb/write and go to RD_A or WR_AW. req_ready is 0 from the next cycle until return to IDLE.
- RD_A: ARVALID=1 with ARADDR stable. On ARVALID&&ARREADY: ARVALID<=0, RREADY<=1, go to RD_D.
- RD_D: on RVALID&&RREADY: capture RDATA/RRESP, RREADY<=0, go to RSP.
- WR_AW: AWVALID and WVALID are both raised on entry. Each drops independently on its own handshake; per-channel done flags track completion. Handshakes in the same cycle or in either order are legal. When both are done: BREADY<=1, go to WR_B.
- WR_B: on BVALID&&BREADY: capture BRESP, BREADY<=0, rsp_rdata=0, go to RSP.
- RSP: rsp_valid=1, data held stable until rsp_ready. On handshake: rsp_valid<=0, req_ready<=1, go to IDLE. No new request is accepted in the same cycle.
- Minimum latency, with ARREADY/RVALID high and rsp_ready high:
  - read: accept at edge 0, ARVALID high after edge 0, RREADY after edge 1, rsp_valid after edge 2 (3 cycles)
  - write: same timing with AW/W in place of AR and B in place of R
- Valid signals are never withdrawn before their handshake (AXI rule), except on reset and on watchdog timeout.
- req_wstrb is passed through unchecked. 0 strobes are legal and still issue a write.

Optional Feature:
- Macro AXI_MASTER_TIMEOUT_EN.
- With the macro: an 8..16-bit counter clears on each state entry and increments in RD_A, RD_D, WR_AW and WR_B. When it reaches TIMEOUT_CYCLES, all valids/readys drop to 0 and the FSM goes to RSP with rsp_resp=2'b10 and rsp_rdata=0. Late slave responses are ignored while not in the matching state.
- Without the macro: no counter; the FSM waits indefinitely.

Decomposition:
- Shared package axi_lite_pkg:
  - resp codes OKAY/EXOKAY/SLVERR/DECERR
  - FSM state encoding
  - default PROT constant
- Natural sub-module: axi_lite_wr_chan, which owns the AW/W valids, the done flags and the both-done indication. The read path stays inline.

Test Plan:
- Read, slave always ready, RDATA=32'hDEADBEEF, RRESP=00 -> rsp_valid 3 cycles after accept, rsp_rdata=DEADBEEF, rsp_resp=00; ARVALID high exactly 1 cycle.
- Write addr 0x1000, data 0xA5A5A5A5, strb 4'b0011; WREADY 2 cycles before AWREADY -> WVALID drops first, AWVALID held, BREADY rises only after both done; BRESP=10 -> rsp_resp=10.
- rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, second req_valid not accepted until the cycle after the rsp handshake.
- ARESETN pulsed while in RD_D with RREADY=1 -> all outputs reach reset values after the next edge, req_ready=1, no rsp_valid.
- AW and W handshake in the same cycle, BVALID the cycle after -> rsp_valid 3 cycles after accept, rsp_rdata=0.
- AXI_MASTER_TIMEOUT_EN with TIMEOUT_CYCLES=16 and ARREADY never asserted -> ARVALID drops after 16 cycles in RD_A, rsp_resp=10, rsp_rdata=0; a later ARREADY/RVALID pulse has no effect.
